// File: rtl/serial_full_subtractor_if.sv
// Operand/result bundle for serial_full_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_full_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow
  );
`endif
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_full_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The single full-subtractor cell works on the current LSBs.
  assign d_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        br_d   = br_next;
        diff_d = (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = DONE;
          borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // After WIDTH-1 shifts the LSBs of sa/sb are the captured MSBs.
          ovf_d    = (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ d_bit);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor (WIDTH=8) against an arithmetic model.
// Exercises the ovf output as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_full_subtractor;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  serial_full_subtractor_if #(.WIDTH(W)) bus ();

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the captured operands.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bin, output logic [W-1:0] d,
                                    output logic bo, output logic ov);
    longint ua, ub, r, sa, sb, sr, full;
    full = longint'(1) << W;
    ua   = longint'(a);
    ub   = longint'(b);
    r    = ua - ub - longint'(bin);
    d    = W'(r & (full - 1));
    bo   = (ua < ub + longint'(bin));
    sa   = (ua >= full / 2) ? ua - full : ua;
    sb   = (ub >= full / 2) ? ub - full : ub;
    sr   = sa - sb - longint'(bin);
    ov   = (sr > full / 2 - 1) || (sr < -(full / 2));
  endfunction

  // Pulses start for one cycle, then counts cycles until done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.bin   = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    tests_run++;
    if (bus.diff !== '0 || bus.borrow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: diff=%h borrow=%b, required 00 0", bus.diff, bus.borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    tests_run++;
    if (bus.ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ovf: ovf=%b, required 0", bus.ovf);
    end
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5] = '{8'h5A, 8'h10, 8'h00, 8'h80, 8'h05};
    logic [W-1:0] vb[5] = '{8'h23, 8'h20, 8'h00, 8'h01, 8'h03};
    logic         vi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ed[5] = '{8'h37, 8'hF0, 8'hFF, 8'h7F, 8'h02};
    logic         eb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vi[i], lat);
      tests_run++;
      if (lat !== W) begin
        tests_failed++;
        $display("[TB] FAIL dir_latency[%0d]: %0d cycles, required %0d", i, lat, W);
      end
      tests_run++;
      if (bus.diff !== ed[i] || bus.borrow !== eb[i]) begin
        tests_failed++;
        $display("[TB] FAIL dir_result[%0d]: diff=%h borrow=%b, required %h %b",
                 i, bus.diff, bus.borrow, ed[i], eb[i]);
      end
`ifdef SERIAL_SUB_OVF_EN
      tests_run++;
      if (bus.ovf !== eo[i]) begin
        tests_failed++;
        $display("[TB] FAIL dir_ovf[%0d]: ovf=%b, required %b", i, bus.ovf, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("[TB] unreachable");
`endif
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.diff !== ed[i]) begin
        tests_failed++;
        $display("[TB] FAIL dir_hold[%0d]: done=%b diff=%h, required 0 %h",
                 i, bus.done, bus.diff, ed[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, ed;
    logic         bin, eb, eo;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      ref_model(a, b, bin, ed, eb, eo);
      do_op(a, b, bin, lat);
      tests_run++;
      if (lat !== W || bus.diff !== ed || bus.borrow !== eb) begin
        tests_failed++;
        $display("[TB] FAIL rand[%0d] %h-%h-%b: lat=%0d diff=%h borrow=%b, required %0d %h %b",
                 i, a, b, bin, lat, bus.diff, bus.borrow, W, ed, eb);
      end
`ifdef SERIAL_SUB_OVF_EN
      tests_run++;
      if (bus.ovf !== eo) begin
        tests_failed++;
        $display("[TB] FAIL rand_ovf[%0d] %h-%h-%b: ovf=%b, required %b", i, a, b, bin, bus.ovf, eo);
      end
`endif
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h23;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ign_busy: busy=%b, required 1", bus.busy);
    end
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        tests_run++;
        if (bus.diff !== 8'h37 || bus.borrow !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL ign_result: diff=%h borrow=%b, required 37 0", bus.diff, bus.borrow);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ign_done_count: %0d pulses, required 1", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.bin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: busy=%b done=%b diff=%h borrow=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.diff, bus.borrow);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: %0d pulses, required 0", dones);
    end
    do_op(8'h5A, 8'h23, 1'b0, lat);
    tests_run++;
    if (lat !== W || bus.diff !== 8'h37 || bus.borrow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_restart: lat=%0d diff=%h borrow=%b, required %0d 37 0",
               lat, bus.diff, bus.borrow, W);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(8'h5A, 8'h23, 1'b0, lat);
    tests_run++;
    if (lat !== W || bus.diff !== 8'h37) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: lat=%0d diff=%h, required %0d 37", lat, bus.diff, W);
    end
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_no_idle: busy=%b done=%b, required 1 0", bus.busy, bus.done);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== W || bus.diff !== 8'hFE || bus.borrow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: lat=%0d diff=%h borrow=%b, required %0d FE 0",
               lat, bus.diff, bus.borrow, W);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.bin      = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
